interrupt_sequencer: RTL and testbench

Consumer side of the processor status flags: at an instruction boundary it takes the CPU's flag byte and program counter and writes them out to the stack page, then reads the interrupt vector and hands the new PC back to the core. It handles the 6502 BRK, IRQ and NMI entry sequences. It sits beside the instruction decoder and drives the CPU's address, data-out and R/W lines while busy.

---
 rtl/interrupt_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - 6502 BRK/IRQ/NMI entry sequencer: push PC and P, fetch vector, load PC.
// The NMI edge detector and 0xFFFA vector path exist only with INTERRUPT_SEQUENCER_NMI_EN defined.
module interrupt_sequencer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sync,
  input  logic        i_brk,
  input  logic        i_irq_n,
  input  logic        i_nmi_n,
  input  logic        i_rdy,
  input  logic [7:0]  i_p,
  input  logic [15:0] i_pc,
  input  logic [7:0]  i_sp,
  input  logic [7:0]  i_data,
  output logic        o_busy,
  output logic [15:0] o_address,
  output logic        o_rw,
  output logic [7:0]  o_db,
  output logic        o_sp_dec,
  output logic [15:0] o_pc,
  output logic        o_pc_load,
  output logic        o_set_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_P, S_VEC_LO, S_VEC_HI, S_LOAD
  } state_t;

  typedef enum logic [1:0] {SRC_BRK, SRC_IRQ, SRC_NMI} src_t;

  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  p_q, p_d;
  logic [7:0]  sp_q, sp_d;
  logic [7:0]  lo_q, lo_d;

  logic        busy_q, busy_d;
  logic [15:0] addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [7:0]  db_q, db_d;
  logic        sp_dec_q, sp_dec_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        pc_load_q, pc_load_d;
  logic        set_i_q, set_i_d;

  logic        nmi_req;
  logic        accept_nmi;
  logic        accept;
  logic [15:0] vec_base;
  logic [7:0]  sp_m1, sp_m2;
  logic [7:0]  p_push;

`ifdef INTERRUPT_SEQUENCER_NMI_EN
  logic nmi_prev_q, nmi_pending_q, nmi_pending_d, nmi_edge;

  assign nmi_edge = nmi_prev_q & ~i_nmi_n;
  // An edge arriving on the accepting cycle is serviced directly instead of being latched.
  assign nmi_req  = nmi_pending_q | nmi_edge;

  always_comb begin
    nmi_pending_d = nmi_pending_q | nmi_edge;
    if (accept_nmi) begin
      nmi_pending_d = nmi_pending_q & nmi_edge;
    end
  end

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      nmi_prev_q    <= 1'b0;
      nmi_pending_q <= 1'b0;
    end else begin
      nmi_prev_q    <= i_nmi_n;
      nmi_pending_q <= nmi_pending_d;
    end
  end
`else
  logic [1:0] unused_nmi;
  assign unused_nmi = {i_nmi_n, accept_nmi};
  assign nmi_req    = 1'b0;
`endif

  assign vec_base = (src_q == SRC_NMI) ? 16'hFFFA : 16'hFFFE;
  assign sp_m1    = sp_q - 8'd1;
  assign sp_m2    = sp_q - 8'd2;
  assign p_push   = {p_q[7:6], 1'b1, (src_q == SRC_BRK), p_q[3:0]};

  // Outputs are computed for the state being entered and registered with it.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    pc_d       = pc_q;
    p_d        = p_q;
    sp_d       = sp_q;
    lo_d       = lo_q;
    busy_d     = 1'b0;
    addr_d     = 16'h0000;
    rw_d       = 1'b1;
    db_d       = 8'h00;
    sp_dec_d   = 1'b0;
    pc_out_d   = pc_out_q;
    pc_load_d  = 1'b0;
    set_i_d    = 1'b0;
    accept     = 1'b0;
    accept_nmi = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_sync) begin
          if (nmi_req) begin
            accept     = 1'b1;
            accept_nmi = 1'b1;
            src_d      = SRC_NMI;
          end else if (!i_irq_n && !i_p[2]) begin
            accept = 1'b1;
            src_d  = SRC_IRQ;
          end else if (i_brk) begin
            accept = 1'b1;
            src_d  = SRC_BRK;
          end
        end
        if (accept) begin
          state_d  = S_PUSH_PCH;
          pc_d     = i_pc;
          p_d      = i_p;
          sp_d     = i_sp;
          busy_d   = 1'b1;
          addr_d   = {8'h01, i_sp};
          rw_d     = 1'b0;
          db_d     = i_pc[15:8];
          sp_dec_d = 1'b1;
        end
      end
      S_PUSH_PCH: begin
        state_d  = S_PUSH_PCL;
        busy_d   = 1'b1;
        addr_d   = {8'h01, sp_m1};
        rw_d     = 1'b0;
        db_d     = pc_q[7:0];
        sp_dec_d = 1'b1;
      end
      S_PUSH_PCL: begin
        state_d  = S_PUSH_P;
        busy_d   = 1'b1;
        addr_d   = {8'h01, sp_m2};
        rw_d     = 1'b0;
        db_d     = p_push;
        sp_dec_d = 1'b1;
      end
      S_PUSH_P: begin
        state_d = S_VEC_LO;
        busy_d  = 1'b1;
        addr_d  = vec_base;
      end
      S_VEC_LO: begin
        busy_d = 1'b1;
        addr_d = vec_base;
        if (i_rdy) begin
          lo_d    = i_data;
          state_d = S_VEC_HI;
          addr_d  = vec_base | 16'h0001;
        end
      end
      S_VEC_HI: begin
        busy_d = 1'b1;
        addr_d = vec_base | 16'h0001;
        if (i_rdy) begin
          state_d   = S_LOAD;
          addr_d    = 16'h0000;
          pc_out_d  = {i_data, lo_q};
          pc_load_d = 1'b1;
          set_i_d   = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      src_q     <= SRC_BRK;
      pc_q      <= 16'h0000;
      p_q       <= 8'h00;
      sp_q      <= 8'h00;
      lo_q      <= 8'h00;
      busy_q    <= 1'b0;
      addr_q    <= 16'h0000;
      rw_q      <= 1'b1;
      db_q      <= 8'h00;
      sp_dec_q  <= 1'b0;
      pc_out_q  <= 16'h0000;
      pc_load_q <= 1'b0;
      set_i_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      pc_q      <= pc_d;
      p_q       <= p_d;
      sp_q      <= sp_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      addr_q    <= addr_d;
      rw_q      <= rw_d;
      db_q      <= db_d;
      sp_dec_q  <= sp_dec_d;
      pc_out_q  <= pc_out_d;
      pc_load_q <= pc_load_d;
      set_i_q   <= set_i_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_address = addr_q;
  assign o_rw      = rw_q;
  assign o_db      = db_q;
  assign o_sp_dec  = sp_dec_q;
  assign o_pc      = pc_out_q;
  assign o_pc_load = pc_load_q;
  assign o_set_i   = set_i_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb/tb_interrupt_sequencer.sv - randomized self-checking bench for interrupt_sequencer.
// Bus activity is predicted per transaction from the entry-sequence rules; the vector ROM lives in the bench.
module tb_interrupt_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_sync, i_brk, i_irq_n, i_nmi_n, i_rdy;
  logic [7:0]  i_p, i_sp, i_data;
  logic [15:0] i_pc;
  logic        o_busy, o_rw, o_sp_dec, o_pc_load, o_set_i;
  logic [15:0] o_address, o_pc;
  logic [7:0]  o_db;

  logic [7:0]  vec_mem [0:5];
  logic [28:0] obs;
  int          vectors = 0;
  int          miscompares = 0;

  interrupt_sequencer dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_sync(i_sync), .i_brk(i_brk),
    .i_irq_n(i_irq_n), .i_nmi_n(i_nmi_n), .i_rdy(i_rdy), .i_p(i_p),
    .i_pc(i_pc), .i_sp(i_sp), .i_data(i_data), .o_busy(o_busy),
    .o_address(o_address), .o_rw(o_rw), .o_db(o_db), .o_sp_dec(o_sp_dec),
    .o_pc(o_pc), .o_pc_load(o_pc_load), .o_set_i(o_set_i)
  );

  always #5 i_clk = ~i_clk;

  assign obs = {o_busy, o_address, o_rw, o_db, o_sp_dec, o_pc_load, o_set_i};

  // Vector ROM at 0xFFFA..0xFFFF; bus returns junk while not ready so late captures are visible.
  always_comb begin
    i_data = 8'hEE;
    if (i_rdy) begin
      case (o_address)
        16'hFFFA: i_data = vec_mem[0];
        16'hFFFB: i_data = vec_mem[1];
        16'hFFFC: i_data = vec_mem[2];
        16'hFFFD: i_data = vec_mem[3];
        16'hFFFE: i_data = vec_mem[4];
        16'hFFFF: i_data = vec_mem[5];
        default:  i_data = 8'h5A;
      endcase
    end
  end

  function automatic logic [28:0] pack(input logic busy, input logic [15:0] addr, input logic rw,
                                       input logic [7:0] db, input logic spdec, input logic pcl,
                                       input logic seti);
    return {busy, addr, rw, db, spdec, pcl, seti};
  endfunction

  // Drives one i_sync request from idle and checks every bus cycle that should follow.
  task automatic run_sequence(input logic brk, input logic irq_n, input logic [7:0] p,
                              input logic [15:0] pc, input logic [7:0] sp, input int stall,
                              input logic nmi_req);
    int          src;
    logic [15:0] vec, exp_pc;
    logic [7:0]  pbyte;
    logic [7:0]  push_db [0:2];
    logic [28:0] exp;
    src = nmi_req ? 1 : (!irq_n && !p[2]) ? 2 : brk ? 3 : 0;
    i_sync = 1'b1; i_brk = brk; i_irq_n = irq_n; i_p = p; i_pc = pc; i_sp = sp; i_rdy = 1'b1;
    @(posedge i_clk);
    i_sync = 1'b0;
    if (src == 0) begin
      exp = pack(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL no_accept: got %h expected %h", obs, exp);
      end
      return;
    end
    vec    = (src == 1) ? 16'hFFFA : 16'hFFFE;
    exp_pc = (src == 1) ? {vec_mem[1], vec_mem[0]} : {vec_mem[5], vec_mem[4]};
    pbyte  = (p | 8'h20) & 8'hEF;
    if (src == 3) pbyte = pbyte | 8'h10;
    push_db[0] = pc[15:8];
    push_db[1] = pc[7:0];
    push_db[2] = pbyte;
    for (int k = 0; k < 3; k++) begin
      exp = pack(1'b1, {8'h01, sp - 8'(k)}, 1'b0, push_db[k], 1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL push%0d: got %h expected %h", k, obs, exp);
      end
      i_sync = 1'($urandom); i_brk = 1'($urandom); i_irq_n = 1'($urandom);
      i_rdy = 1'($urandom); i_pc = 16'($urandom); i_sp = 8'($urandom); i_p = 8'($urandom);
      @(posedge i_clk);
    end
    for (int s = 0; s <= stall; s++) begin
      exp = pack(1'b1, vec, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL vec_lo%0d: got %h expected %h", s, obs, exp);
      end
      i_rdy = (s == stall);
      i_sync = 1'($urandom);
      @(posedge i_clk);
    end
    exp = pack(1'b1, vec | 16'h0001, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL vec_hi: got %h expected %h", obs, exp);
    end
    i_rdy = 1'b1;
    @(posedge i_clk);
    exp = pack(1'b1, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (obs !== exp || o_pc !== exp_pc) begin
      miscompares++;
      $display("FAIL load: got %h pc %h expected %h pc %h", obs, o_pc, exp, exp_pc);
    end
    i_sync = 1'b0;
    @(posedge i_clk);
    exp = pack(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL after_load: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reset;
    logic [28:0] exp;
    i_reset = 1'b1; i_sync = 1'b0; i_brk = 1'b0; i_irq_n = 1'b1; i_nmi_n = 1'b1;
    i_rdy = 1'b1; i_p = 8'h00; i_pc = 16'h0000; i_sp = 8'hFF;
    @(posedge i_clk);
    #1;
    exp = pack(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp || o_pc !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset: got %h pc %h expected %h pc 0000", obs, o_pc, exp);
    end
    @(posedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic test_brk;
    vec_mem[4] = 8'h00; vec_mem[5] = 8'h90;
    run_sequence(1'b1, 1'b1, 8'h81, 16'h8002, 8'hFD, 0, 1'b0);
  endtask

  task automatic test_irq_mask;
    vec_mem[4] = 8'h34; vec_mem[5] = 8'h12;
    run_sequence(1'b0, 1'b0, 8'h04, 16'h1234, 8'hF0, 0, 1'b0);
    run_sequence(1'b0, 1'b0, 8'h00, 16'h4321, 8'hF0, 0, 1'b0);
  endtask

  task automatic test_wrap;
    vec_mem[4] = 8'hCD; vec_mem[5] = 8'hAB;
    run_sequence(1'b1, 1'b1, 8'hFF, 16'hC0DE, 8'h01, 0, 1'b0);
  endtask

  task automatic test_stall;
    vec_mem[4] = 8'h11; vec_mem[5] = 8'h22;
    run_sequence(1'b1, 1'b1, 8'h00, 16'h0200, 8'h80, 3, 1'b0);
  endtask

  task automatic test_nmi;
    vec_mem[0] = 8'h78; vec_mem[1] = 8'h56; vec_mem[4] = 8'hBC; vec_mem[5] = 8'h9A;
`ifdef INTERRUPT_SEQUENCER_NMI_EN
    i_nmi_n = 1'b0;
    run_sequence(1'b0, 1'b0, 8'h00, 16'h3000, 8'hFF, 0, 1'b1);
    run_sequence(1'b0, 1'b0, 8'h00, 16'h3001, 8'hFC, 0, 1'b0);
    i_nmi_n = 1'b1;
    @(posedge i_clk);
    i_nmi_n = 1'b0;
    @(posedge i_clk);
    i_nmi_n = 1'b1;
    repeat (2) @(posedge i_clk);
    run_sequence(1'b1, 1'b0, 8'h00, 16'h5000, 8'h40, 1, 1'b1);
    run_sequence(1'b1, 1'b0, 8'h00, 16'h5001, 8'h3D, 0, 1'b0);
`else
    i_nmi_n = 1'b0;
    run_sequence(1'b0, 1'b1, 8'h00, 16'h3000, 8'hFF, 0, 1'b0);
    run_sequence(1'b0, 1'b0, 8'h00, 16'h3001, 8'hFC, 0, 1'b0);
    i_nmi_n = 1'b1;
    @(posedge i_clk);
`endif
  endtask

  task automatic test_reset_mid;
    logic [28:0] exp;
    vec_mem[4] = 8'h00; vec_mem[5] = 8'h90;
    i_sync = 1'b1; i_brk = 1'b1; i_irq_n = 1'b1; i_p = 8'h00; i_pc = 16'h6000; i_sp = 8'h90;
    @(posedge i_clk);
    i_sync = 1'b0; i_brk = 1'b0;
    i_nmi_n = 1'b0;
    @(posedge i_clk);
    exp = pack(1'b1, 16'h018F, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL pre_reset_pcl: got %h expected %h", obs, exp);
    end
    #2 i_reset = 1'b1;
    #1;
    exp = pack(1'b0, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp || o_pc !== 16'h0000) begin
      miscompares++;
      $display("FAIL async_reset: got %h pc %h expected %h pc 0000", obs, o_pc, exp);
    end
    @(posedge i_clk);
    i_reset = 1'b0;
    i_nmi_n = 1'b1;
    @(posedge i_clk);
    run_sequence(1'b0, 1'b1, 8'h00, 16'h7000, 8'h20, 0, 1'b0);
    @(posedge i_clk);
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy %b expected 0", o_busy);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      for (int j = 0; j < 6; j++) vec_mem[j] = 8'($urandom);
      run_sequence(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge i_clk);
    end
  endtask

  initial begin
    for (int j = 0; j < 6; j++) vec_mem[j] = 8'h00;
    test_reset();
    test_brk();
    test_irq_mask();
    test_wrap();
    test_stall();
    test_nmi();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
